regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised multi-read-port register file; successor to the fixed 32x32, 2-read-port regfile.
//  Configurable width, depth and read-port count; optional hardwired-zero entry 0; optional write-to-read bypass.
//  Reset performs a sequenced sweep that zeroes one entry per cycle, so the array maps to distributed RAM.
//  Sits in the CPU decode stage, between the instruction decoder and the ALU operand muxes.
// PARAMETERS
//  WIDTH     32  data bits per entry
//  DEPTH     32  number of entries, >=2; need not be a power of 2
//  NRD       2   number of combinational read ports, >=1
//  ZERO_REG  1   1: entry 0 always reads 0 and writes to it are dropped
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
//  AW        $clog2(DEPTH)  derived address width; not overridable
// PORTS
//  Clk   in   1          rising-edge clock
//  Clr   in   1          synchronous active-high reset; starts the clear sweep
//  We    in   1          write enable
//  Wr    in   AW         write address
//  D     in   WIDTH      write data
//  Ra    in   NRD*AW     read addresses; port i = Ra[i*AW +: AW]
//  Q     out  NRD*WIDTH  read data; port i = Q[i*WIDTH +: WIDTH]
//  Busy  out  1          1 while the clear sweep runs; file not usable
// BEHAVIOUR
//  FSM states: IDLE and CLEAR. Sweep pointer ptr is AW bits wide.
//  - Clr=1 at an edge: next state CLEAR, ptr<=0. Applies from any state, including mid-sweep (sweep restarts).
//  - While Clr is held high, the FSM stays in CLEAR with ptr=0.
//  - CLEAR with Clr=0: each edge writes 0 to mem[ptr] and increments ptr.
//  - On the edge that writes entry DEPTH-1, next state is IDLE.
//  - Busy = (state==CLEAR). It is high exactly DEPTH cycles after the last Clr edge.
//  - Power-up state is undefined until the first Clr.
//  Reset values: Busy=1 and all Q=0 from the first edge with Clr=1 until the sweep ends.
//  Writes:
//  - In IDLE, at the edge with We=1, mem[Wr]<=D.
//  - The write is dropped if Wr>=DEPTH, if (ZERO_REG && Wr==0), or if Busy=1.
//  - We is ignored during CLEAR. A sweep write never coincides with a user write.
//  Reads: combinational, 0-cycle latency. Each port i is evaluated independently:
//  - Busy=1                                  -> 0
//  - Ra_i>=DEPTH                             -> 0
//  - ZERO_REG && Ra_i==0                     -> 0
//  - BYPASS && We && Wr==Ra_i, write legal   -> D (new data, same cycle)
//  - otherwise                               -> mem[Ra_i]
//  - With BYPASS=0, a same-address read returns the old data until the edge.
//  Several ports may read the same address; all return the same value.
//  The array itself has no reset other than the sweep.
// TESTING
//  1. Clr 1 cycle, then idle: Busy=1 for exactly DEPTH cycles (32). Then read all 32 entries via port 0 -> all 0.
//  2. Write 0xDEADBEEF to addr 5, then Ra0=5, Ra1=5 -> both ports 0xDEADBEEF.
//     Write addr 0 with 0xFFFFFFFF -> addr 0 reads 0.
//  3. BYPASS=1: We=1, Wr=7, D=0x12345678, Ra0=7 in the same cycle -> Q0=0x12345678 before the edge.
//     BYPASS=0 -> Q0 holds the old value (0), and reads 0x12345678 the next cycle.
//  4. Write addr 9 = 0xA5A5A5A5; Clr 1 cycle; Clr again at sweep ptr=20.
//     -> Busy stays high 32 cycles after the second Clr; writes during Busy are dropped; addr 9 reads 0 afterwards.
//  5. DEPTH=20, NRD=3: write addr 25 is dropped; Ra=25 -> 0.
//     Three ports read addrs 1, 19, 0 after writes of 0x1, 0x13 -> Q = 0x1, 0x13, 0.
//  6. Random We/Wr/D/Ra for 10k cycles against a reference model with occasional Clr -> no mismatch on any port.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file with combinational read ports, optional hardwired-zero
// entry 0, optional same-cycle write bypass, and a one-entry-per-cycle clear sweep.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic                 We,
  input  logic [AW-1:0]        Wr,
  input  logic [WIDTH-1:0]     D,
  input  logic [NRD*AW-1:0]    Ra,
  output logic [NRD*WIDTH-1:0] Q,
  output logic                 Busy
);

  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    CLEAR = 1'b1;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  logic [0:0]       state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic is_zero_entry(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign Busy  = (state == CLEAR);
  assign wr_ok = We && !Busy && in_range(Wr) && !is_zero_entry(Wr);

  // Control: Clr (re)starts the sweep from entry 0 and holds it there while asserted.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == LAST)
        state <= IDLE;
    end
  end

  // Single write port shared by the sweep and user writes; they are mutually exclusive.
  always_ff @(posedge Clk) begin
    if (!Clr && (state == CLEAR))
      mem[ptr] <= '0;
    else if (wr_ok)
      mem[Wr] <= D;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = Ra[i*AW +: AW];

    always_comb begin
      rd = '0;
      if (!Busy && in_range(ra) && !is_zero_entry(ra)) begin
        if ((BYPASS != 0) && wr_ok && (Wr == ra))
          rd = D;
        else
          rd = mem[ra];
      end
    end

    assign Q[i*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven with shared write/clear stimulus,
// checked every cycle against an array model plus directed literal expectations.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        clr;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] d;
  logic [4:0]  ra [3];
  logic [9:0]  ra01;
  logic [14:0] ra012;
  logic [63:0] q_a, q_b;
  logic [95:0] q_c;
  logic        busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  assign ra01  = {ra[1], ra[0]};
  assign ra012 = {ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .Clk(clk), .Clr(clr), .We(we), .Wr(wr), .D(d), .Ra(ra01), .Q(q_a), .Busy(busy_a));

  regfile_param #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .Clk(clk), .Clr(clr), .We(we), .Wr(wr), .D(d), .Ra(ra01), .Q(q_b), .Busy(busy_b));

  regfile_param #(.WIDTH(32), .DEPTH(20), .NRD(3), .ZERO_REG(1), .BYPASS(1)) u_c (
    .Clk(clk), .Clr(clr), .We(we), .Wr(wr), .D(d), .Ra(ra012), .Q(q_c), .Busy(busy_c));

  // Reference model: per configuration, entry contents and remaining busy cycles.
  int          depth_k [3] = '{32, 32, 20};
  int          nrd_k   [3] = '{2, 2, 3};
  bit          byp_k   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mm [3][32];
  int          busy_left [3] = '{0, 0, 0};
  bit          model_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_q(input int k, input logic [4:0] a);
    if (busy_left[k] > 0) return 32'h0;
    if (int'(a) >= depth_k[k]) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp_k[k] && we && (wr == a)) return d;
    return mm[k][a];
  endfunction

  function automatic logic [31:0] dut_q(input int k, input int p);
    case (k)
      0:       return q_a[p*32 +: 32];
      1:       return q_b[p*32 +: 32];
      default: return q_c[p*32 +: 32];
    endcase
  endfunction

  function automatic logic dut_busy(input int k);
    case (k)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        for (int e = 0; e < 32; e++) mm[k][e] = 32'h0;
        busy_left[k] = depth_k[k];
      end else if (busy_left[k] > 0) begin
        busy_left[k] = busy_left[k] - 1;
      end else if (we && (int'(wr) < depth_k[k]) && (wr != 5'd0)) begin
        mm[k][wr] = d;
      end
    end
    if (clr) model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy_i%0d", k), {31'b0, dut_busy(k)}, {31'b0, busy_left[k] > 0});
        for (int p = 0; p < nrd_k[k]; p++)
          chk($sformatf("q_i%0d_p%0d_ra%0d", k, p, ra[p]), dut_q(k, p), exp_q(k, ra[p]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    clr = 1'b0; we = 1'b0; wr = '0; d = '0;
    ra[0] = '0; ra[1] = '0; ra[2] = '0;
    repeat (2) step();

    // Single-cycle clear, then the whole file reads zero.
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      step();
    end
    chk("busy_len_first", 32'(n), 32'd32);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a);
      #1;
      chk($sformatf("clear_rd_%0d", a), q_a[31:0], 32'h0);
      step();
    end

    // Plain write, two ports on one address, hardwired zero entry.
    we = 1'b1; wr = 5'd5; d = 32'hDEADBEEF;
    step();
    we = 1'b0; ra[0] = 5'd5; ra[1] = 5'd5;
    #1;
    chk("rd5_p0", q_a[31:0], 32'hDEADBEEF);
    chk("rd5_p1", q_a[63:32], 32'hDEADBEEF);
    we = 1'b1; wr = 5'd0; d = 32'hFFFFFFFF;
    step();
    we = 1'b0; ra[0] = 5'd0;
    #1;
    chk("rd0_zero", q_a[31:0], 32'h0);

    // Same-cycle bypass versus no bypass.
    ra[0] = 5'd7; we = 1'b1; wr = 5'd7; d = 32'h12345678;
    #1;
    chk("bypass_on", q_a[31:0], 32'h12345678);
    chk("bypass_off_old", q_b[31:0], 32'h0);
    step();
    we = 1'b0;
    #1;
    chk("bypass_off_new", q_b[31:0], 32'h12345678);

    // Restarted sweep: busy runs a full depth after the second Clr; busy writes dropped.
    we = 1'b1; wr = 5'd9; d = 32'hA5A5A5A5;
    step();
    we = 1'b0; ra[0] = 5'd9;
    #1;
    chk("rd9_before_clr", q_a[31:0], 32'hA5A5A5A5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (20) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    we = 1'b1; wr = 5'd3; d = 32'h33333333;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      if (n == 5) we = 1'b0;
      step();
    end
    we = 1'b0;
    chk("busy_len_restart", 32'(n), 32'd32);
    ra[0] = 5'd9; ra[1] = 5'd3;
    #1;
    chk("rd9_after_clr", q_a[31:0], 32'h0);
    chk("rd3_busy_write", q_a[63:32], 32'h0);

    // Depth-20, three-port configuration.
    we = 1'b1; wr = 5'd25; d = 32'h00000BAD;
    step();
    wr = 5'd1; d = 32'h1;
    step();
    wr = 5'd19; d = 32'h13;
    step();
    we = 1'b0; ra[0] = 5'd1; ra[1] = 5'd19; ra[2] = 5'd0;
    #1;
    chk("c_p0_rd1", q_c[31:0], 32'h1);
    chk("c_p1_rd19", q_c[63:32], 32'h13);
    chk("c_p2_rd0", q_c[95:64], 32'h0);
    ra[2] = 5'd25;
    #1;
    chk("c_p2_rd25", q_c[95:64], 32'h0);
    step();

    // Random traffic with occasional clears; the per-cycle compare does the checking.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      clr   = ($urandom_range(0, 499) == 0);
      we    = 1'($urandom_range(0, 1));
      wr    = 5'($urandom_range(0, 31));
      d     = $urandom;
      ra[0] = 5'($urandom_range(0, 31));
      ra[1] = 5'($urandom_range(0, 31));
      ra[2] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra[0] = wr;
      if ($urandom_range(0, 7) == 0) ra[2] = wr;
      step();
    end
    clr = 1'b0; we = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
